dm_responder: RTL and testbench
===============================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter: LATENCY, default 2, clock edges from request acceptance to done assertion (legal 1..15).
REQ-002 Parameter: INIT_ZERO, default 1, when 1 the memory array is zero-filled at elaboration.
REQ-003 Port: clk  input  1  single clock for all state and memory.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: ena  input  1  request valid, driven by processor data-memory stage.
REQ-006 Port: wea  input  1  1 = store, 0 = load; meaningful only with ena.
REQ-007 Port: addra  input  7  word address, 128 words.
REQ-008 Port: dina  input  32  store data.
REQ-009 Port: douta  output  32  load data, registered.
REQ-010 Port: done  output  1  one-cycle completion pulse for the accepted request.
REQ-011 Port: busy  output  1  high while a request is held (BUSY or DONE state).

Function
REQ-012 FSM states: IDLE, BUSY, DONE; 4-bit down-counter cnt.
REQ-013 IDLE with ena=1 at a rising edge: capture addra, dina, wea into internal registers; load cnt=LATENCY-1; go to BUSY.
REQ-014 IDLE with ena=0: remain IDLE; done=0.
REQ-015 BUSY with cnt!=0: decrement cnt; ignore all request inputs.
REQ-016 BUSY with cnt==0: execute captured op at that edge; store writes mem[addr]=data; load writes douta=mem[addr]; set done=1; go to DONE.
REQ-017 Result: done is high during the cycle after edge k+LATENCY, where k is the acceptance edge.
REQ-018 DONE: at the next edge clear done, go to IDLE; ena is ignored in DONE, so back-to-back requests are spaced LATENCY+2 edges apart.
REQ-019 douta holds the last load result; stores and idle cycles leave it unchanged.
REQ-020 Dropping ena or changing addra/dina/wea during BUSY does not abort or alter the captured request.
REQ-021 A load after a store to the same address returns the stored value (no stale read).
REQ-022 The 7-bit address spans the full array; no out-of-range case exists.
REQ-023 busy = (state != IDLE), combinational from the state register.

Reset
REQ-024 rst=0 asynchronously forces state=IDLE, cnt=0, done=0, douta=0, and clears the captured request registers.
REQ-025 Reset does not clear memory contents.
REQ-026 Reset during BUSY drops the pending request: a pending store is not written and done does not pulse.
REQ-027 After rst deasserts, the first rising edge with ena=1 is accepted as a new request.

Structure
REQ-028 Shared package dm_pkg holds ADDR_W=7, DATA_W=32, DEPTH=128 and the state enum (IDLE, BUSY, DONE).
REQ-029 One sub-module, dm_array: single-port synchronous 128x32 RAM with write enable and registered read, instantiated once.
REQ-030 The FSM, counter and capture registers reside in dm_responder; the total is 120-400 RTL lines.

Verification
REQ-031 LATENCY=2: store addr=5, data=0xDEADBEEF accepted at edge 0 -> done high only after edge 2; douta unchanged.
REQ-032 Then load addr=5 -> douta=0xDEADBEEF in the same cycle done pulses; busy high for exactly 3 cycles.
REQ-033 ena held high continuously with addra=0..3 loads -> one accepted request every 4 edges (LATENCY+2); each done is a single cycle.
REQ-034 Load of addr=9 accepted, then addra changed to 10 and ena dropped during BUSY -> douta=mem[9]; done still pulses.
REQ-035 rst pulsed low mid-BUSY on a store of 0x12345678 to addr=3 -> done never pulses; a later load of addr 3 returns the prior value (0 with INIT_ZERO=1).
REQ-036 LATENCY=1 and LATENCY=15: store/load of addr=127 -> done after edge 1 and edge 15 respectively; data matches.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared constants and state encoding for the data-memory responder.
package dm_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 128;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/dm_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, with a registered read port.
// The read register only moves on loads, so it holds the last load result.
module dm_array
    import dm_pkg::*;
#(
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    // Contents survive reset; only the read register is cleared.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: (INIT_ZERO ? {DATA_W{1'b0}} : {DATA_W{1'bx}})};

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
        end else if (en && !we) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Fixed-latency data-memory responder: captures one request, waits LATENCY
// edges, executes it against dm_array and pulses done for one cycle.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned LATENCY   = 2,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta,
    output logic              done,
    output logic              busy
);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                done_q;
    logic                exec;

    // The array performs the captured op on the same edge the FSM leaves BUSY.
    assign exec = (state_q == BUSY) && (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (ena) begin
                        addr_q  <= addra;
                        data_q  <= dina;
                        we_q    <= wea;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign done = done_q;
    assign busy = (state_q != IDLE);

    dm_array #(
        .INIT_ZERO(INIT_ZERO)
    ) u_array (
        .clk (clk),
        .rst (rst),
        .en  (exec),
        .we  (we_q),
        .addr(addr_q),
        .din (data_q),
        .dout(douta)
    );

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder at LATENCY 2, 1 and 15: requests push the
// expected douta and done cycle; a monitor pops and compares on every done.
module tb_dm_responder;

    localparam int LATS [3] = '{2, 1, 15};

    typedef struct {
        logic [31:0] dout;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ena   [3];
    logic        wea   [3];
    logic [6:0]  addra [3];
    logic [31:0] dina  [3];
    logic [31:0] douta [3];
    logic        done  [3];
    logic        busy  [3];

    int          cyc;
    int          n_cmp;
    int          n_bad;
    exp_t        q [3][$];
    logic [31:0] mdl      [3][128];
    logic [31:0] mdl_dout [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dm_responder #(
            .LATENCY  (LATS[g]),
            .INIT_ZERO(1'b1)
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .ena  (ena[g]),
            .wea  (wea[g]),
            .addra(addra[g]),
            .dina (dina[g]),
            .douta(douta[g]),
            .done (done[g]),
            .busy (busy[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int i, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [dut%0d]: got 0x%h, want 0x%h", nm, i, act, exp);
        end
    endtask

    task automatic push_exp(input int i, input logic [31:0] d, input int c);
        exp_t e;
        e.dout = d;
        e.cyc  = c;
        q[i].push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (done[i] === 1'b1) begin
                    if (q[i].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done [dut%0d]: done=1 at cycle %0d, want 0",
                                 i, cyc);
                    end else begin
                        e = q[i].pop_front();
                        check("douta", i, douta[i], e.dout);
                        check("done_cycle", i, cyc, e.cyc);
                    end
                end
            end
        end
    endtask

    // One request; request inputs are disturbed right after acceptance.
    task automatic issue(input int i, input bit we, input int a, input logic [31:0] d);
        int nb;
        @(negedge clk);
        ena[i]   = 1'b1;
        wea[i]   = we;
        addra[i] = 7'(a);
        dina[i]  = d;
        if (we) mdl[i][a] = d;
        else    mdl_dout[i] = mdl[i][a];
        push_exp(i, mdl_dout[i], cyc + 1 + LATS[i]);
        nb = 0;
        for (int t = 0; t < LATS[i] + 4; t++) begin
            @(negedge clk);
            if (t == 0) begin
                ena[i]   = 1'b0;
                wea[i]   = ~we;
                addra[i] = 7'(a + 1);
                dina[i]  = ~d;
            end
            if (busy[i] === 1'b1) nb++;
        end
        check("busy_cycles", i, nb, LATS[i] + 1);
        check("pending", i, q[i].size(), 0);
        q[i].delete();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ena[i]      = 1'b0;
            wea[i]      = 1'b0;
            addra[i]    = '0;
            dina[i]     = '0;
            mdl_dout[i] = '0;
            for (int a = 0; a < 128; a++) mdl[i][a] = '0;
        end
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_busy", i, busy[i], 0);
            check("rst_done", i, done[i], 0);
            check("rst_douta", i, douta[i], 0);
        end
        rst = 1'b1;

        // Store leaves douta at 0, then the load returns it.
        issue(0, 1'b1, 5, 32'hDEAD_BEEF);
        issue(0, 1'b0, 5, 32'h0);
        issue(0, 1'b1, 0, 32'h1111_0000);
        issue(0, 1'b1, 1, 32'h2222_0001);
        issue(0, 1'b1, 2, 32'h3333_0002);

        // ena held high: loads of 0..3 accepted every LATENCY+2 edges.
        @(negedge clk);
        ena[0] = 1'b1;
        wea[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            addra[0]    = 7'(k);
            mdl_dout[0] = mdl[0][k];
            push_exp(0, mdl_dout[0], cyc + 3);
            repeat (4) @(negedge clk);
        end
        ena[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("held_pending", 0, q[0].size(), 0);
        q[0].delete();

        // Address moves to 10 and ena drops while busy; mem[9] is returned.
        issue(0, 1'b1, 9, 32'h0000_0909);
        issue(0, 1'b0, 9, 32'h0);

        // Reset mid-BUSY drops a store to addr 3.
        @(negedge clk);
        ena[0]   = 1'b1;
        wea[0]   = 1'b1;
        addra[0] = 7'd3;
        dina[0]  = 32'h1234_5678;
        @(negedge clk);
        ena[0] = 1'b0;
        check("busy_before_rst", 0, busy[0], 1);
        rst = 1'b0;
        #1;
        check("async_rst_busy", 0, busy[0], 0);
        check("async_rst_douta", 0, douta[0], 0);
        for (int i = 0; i < 3; i++) mdl_dout[i] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        issue(0, 1'b0, 3, 32'h0);
        issue(0, 1'b0, 5, 32'h0);

        issue(1, 1'b1, 127, 32'hA5A5_0001);
        issue(1, 1'b0, 127, 32'h0);
        issue(2, 1'b1, 127, 32'h5A5A_000F);
        issue(2, 1'b0, 127, 32'h0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
